// File: rtl/layer1_buf_ctrl_pkg.sv
// Shared constants and bundle types for the layer1 buffer controller.
// Imported by the interface, the arbiter and the top.
package layer1_buf_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 128;
    localparam int DEPTH  = 912;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef struct packed {
        logic              req;
        logic [ADDR_W-1:0] addr;
    } rd_req_t;

    typedef struct packed {
        logic              valid;
        logic              id;
        logic [DATA_W-1:0] data;
    } rd_rsp_t;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return a < ADDR_W'(DEPTH);
    endfunction

endpackage

// File: rtl/layer1_buf_ctrl_if.sv
// Producer write port, two read requesters and the read response.
// master = clients, slave = the buffer controller.
interface layer1_buf_ctrl_if;
    import layer1_buf_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    logic              r0_req;
    logic [ADDR_W-1:0] r0_addr;
    logic              r0_gnt;
    logic              r1_req;
    logic [ADDR_W-1:0] r1_addr;
    logic              r1_gnt;

    logic              rd_valid;
    logic              rd_id;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output wr_valid, wr_addr, wr_data,
        output r0_req, r0_addr, r1_req, r1_addr,
        input  wr_ready, r0_gnt, r1_gnt,
        input  rd_valid, rd_id, rd_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data,
        input  r0_req, r0_addr, r1_req, r1_addr,
        output wr_ready, r0_gnt, r1_gnt,
        output rd_valid, rd_id, rd_data
    );

endinterface

// File: rtl/layer1_buf_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; priority flips only when a grant is issued.
// ptr_q = 0 gives requester 0 priority on a tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic [1:0] elig,
    output logic [1:0] gnt
);

    logic ptr_q;
    logic ptr_d;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        unique case (elig)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        if (gnt[0]) begin
            ptr_d = 1'b1;
        end
        if (gnt[1]) begin
            ptr_d = 1'b0;
        end
        if (clear) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/layer1_buf_ctrl.sv
// Layer1 buffer controller: write port A, round-robin shared read port B,
// A/B same-address collision avoidance, frame fill counter and range errors.
module layer1_buf_ctrl
    import layer1_buf_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    layer1_buf_ctrl_if.slave  bus,
    output logic              frame_done,
    output logic [ADDR_W-1:0] wr_cnt,
    output logic              err_oor,
    output logic              sram_oea,
    output logic              sram_oeb,
    output logic              sram_wean,
    output logic              sram_webn,
    output logic [ADDR_W-1:0] sram_a,
    output logic [ADDR_W-1:0] sram_b,
    output logic [DATA_W-1:0] sram_dia,
    output logic [DATA_W-1:0] sram_dib,
    input  logic [DATA_W-1:0] sram_dob
);

    logic              active;
    logic              wr_acc;
    logic              wr_ok;
    logic              wr_bad;
    rd_req_t           rq0;
    rd_req_t           rq1;
    logic [1:0]        elig;
    logic [1:0]        gnt;
    logic              rd_any;
    logic [ADDR_W-1:0] sel_addr;
    logic              rd_ok;
    logic              rd_bad;
    rd_rsp_t           rsp;

    logic [ADDR_W-1:0] a_q, a_d;
    logic [ADDR_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] dia_q, dia_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              fd_q, fd_d;
    logic              err_q, err_d;
    logic              rv_q, rv_d;
    logic              rid_q, rid_d;

    // Reset gating keeps every strobe quiet while rst_n is low.
    assign active = rst_n & ~clear;
    assign wr_acc = bus.wr_valid & active;
    assign wr_ok  = wr_acc & in_range(bus.wr_addr);
    assign wr_bad = wr_acc & ~in_range(bus.wr_addr);

    assign rq0 = '{req: bus.r0_req, addr: bus.r0_addr};
    assign rq1 = '{req: bus.r1_req, addr: bus.r1_addr};

    // A read of the address being written waits a cycle for the new data.
    always_comb begin
        elig    = 2'b00;
        elig[0] = rq0.req & active & ~(wr_acc & (rq0.addr == bus.wr_addr));
        elig[1] = rq1.req & active & ~(wr_acc & (rq1.addr == bus.wr_addr));
    end

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .elig  (elig),
        .gnt   (gnt)
    );

    assign rd_any   = |gnt;
    assign sel_addr = gnt[1] ? rq1.addr : rq0.addr;
    assign rd_ok    = rd_any & in_range(sel_addr);
    assign rd_bad   = rd_any & ~in_range(sel_addr);

    assign bus.wr_ready = wr_acc;
    assign bus.r0_gnt   = gnt[0];
    assign bus.r1_gnt   = gnt[1];

    assign sram_oea  = 1'b0;
    assign sram_wean = ~wr_ok;
    assign sram_a    = wr_ok ? bus.wr_addr : a_q;
    assign sram_dia  = wr_ok ? bus.wr_data : dia_q;
    assign sram_webn = 1'b1;
    assign sram_dib  = '0;
    assign sram_oeb  = rd_ok;
    assign sram_b    = rd_ok ? sel_addr : b_q;

    always_comb begin
        a_d   = sram_a;
        dia_d = sram_dia;
        b_d   = sram_b;
        rv_d  = rd_ok;
        rid_d = rd_ok & gnt[1];
    end

    always_comb begin
        cnt_d = cnt_q;
        fd_d  = 1'b0;
        unique case (1'b1)
            clear: begin
                cnt_d = '0;
            end
            wr_ok && (cnt_q == LAST_ADDR): begin
                cnt_d = '0;
                fd_d  = 1'b1;
            end
            wr_ok && (cnt_q != LAST_ADDR): begin
                cnt_d = cnt_q + ADDR_W'(1);
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
    end

    always_comb begin
        err_d = err_q | wr_bad | rd_bad;
        if (clear) begin
            err_d = 1'b0;
        end
    end

    always_comb begin
        rsp       = '0;
        rsp.valid = rv_q;
        rsp.id    = rid_q;
        rsp.data  = rv_q ? sram_dob : '0;
    end

    assign bus.rd_valid = rsp.valid;
    assign bus.rd_id    = rsp.id;
    assign bus.rd_data  = rsp.data;

    assign frame_done = fd_q;
    assign wr_cnt     = cnt_q;
    assign err_oor    = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            dia_q <= '0;
            cnt_q <= '0;
            fd_q  <= 1'b0;
            err_q <= 1'b0;
            rv_q  <= 1'b0;
            rid_q <= 1'b0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            dia_q <= dia_d;
            cnt_q <= cnt_d;
            fd_q  <= fd_d;
            err_q <= err_d;
            rv_q  <= rv_d;
            rid_q <= rid_d;
        end
    end

endmodule

// File: doc/layer1_buf_ctrl.md
Name: layer1_buf_ctrl

Overview:
- Controller and arbiter for the layer1 local buffer: 912 words x 128 bits, dual-port SRAM behind its wrapper.
- Port A is write-only and owned by the layer1 producer (conv/pool output stream).
- Port B is read-only and shared round-robin between two consumers: r0 = layer2 fetch, r1 = readout/debug.
- Guarantees no same-address A/B access in one cycle, because the wrapper's collision remap would corrupt a write. Also tracks frame fill and out-of-range errors.

Parameters:
ADDR_W, 10, SRAM address width
DATA_W, 128, SRAM word width
DEPTH, 912, valid words; addresses 0..DEPTH-1

Ports:
clk  in  1  clock, also drives wrapper CK
rst_n  in  1  async active-low reset
clear  in  1  sync pulse: zero wr_cnt, err_oor, rr pointer
wr_valid  in  1  producer write request
wr_ready  out  1  write accepted this cycle
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
r0_req / r1_req  in  1  read requests
r0_addr / r1_addr  in  ADDR_W  read addresses
r0_gnt / r1_gnt  out  1  read accepted this cycle
rd_valid  out  1  read data valid
rd_id  out  1  0 = r0, 1 = r1
rd_data  out  DATA_W  read data
frame_done  out  1  one-cycle pulse when DEPTH writes have been accepted
wr_cnt  out  ADDR_W  accepted writes in the current frame
err_oor  out  1  sticky: a request had addr >= DEPTH
sram_oea, sram_oeb, sram_wean, sram_webn  out  1  wrapper controls
sram_a, sram_b  out  ADDR_W  wrapper addresses
sram_dia, sram_dib  out  DATA_W  wrapper write data
sram_dob  in  DATA_W  wrapper port-B read data

Behaviour:
- Reset values:
  - All outputs 0, except sram_wean = 1 and sram_webn = 1.
  - rr pointer = 0, meaning r0 has priority.
- Port A:
  - wr_ready = wr_valid & ~clear (combinational).
  - On an accepted write with wr_addr < DEPTH: sram_wean = 0, sram_a = wr_addr, sram_dia = wr_data, sram_oea = 0.
  - Accepted write with wr_addr >= DEPTH: consumed, SRAM untouched, err_oor set.
  - When idle: wean = 1, a holds its last value.
- Port B:
  - sram_webn tied 1, sram_dib tied 0.
  - A read is eligible when req is high, ~clear, and its address differs from wr_addr whenever a write is accepted in the same cycle.
  - Write has priority on collision: the read gnt stays 0 and is retried next cycle, so it returns the newly written data.
- Arbitration:
  - Only one eligible requester: grant it.
  - Both eligible: grant the one not granted last (rr pointer).
  - rr pointer updates only on a grant.
  - gnt is combinational in the same cycle as req.
- Granted read with addr < DEPTH: sram_oeb = 1, sram_b = addr.
- Granted read with addr >= DEPTH: consumed, err_oor set, no rd_valid.
- Read latency: 1 cycle. rd_valid, rd_id registered at t+1; rd_data = sram_dob while rd_valid. Back-to-back grants give back-to-back rd_valid.
- Frame counter:
  - wr_cnt increments per accepted in-range write.
  - On reaching DEPTH-1 -> DEPTH: wr_cnt wraps to 0 and frame_done pulses in the next cycle.
  - clear has priority over any increment.
- Reset mid-operation:
  - An in-flight rd_valid is dropped.
  - SRAM contents are not cleared.
- Simultaneous clear and requests: no grants, no SRAM enables that cycle.

Decomposition:
- Package layer1_buf_pkg:
  - ADDR_W, DATA_W, DEPTH constants.
  - typedef rd_req_t {logic req; logic [ADDR_W-1:0] addr;}.
  - typedef rd_rsp_t {logic valid; logic id; logic [DATA_W-1:0] data;}.
- Sub-module rr_arb2: 2-way round-robin arbiter with eligible-mask input and update-on-grant.
- Top instantiates rr_arb2 plus the counter, error and response pipeline.

Test Plan:
- Reset, then write addr 5 = 0xA5..A5 followed by an r0 read of 5 -> r0_gnt same cycle; next cycle rd_valid = 1, rd_id = 0, rd_data = 0xA5..A5.
- r0 and r1 request every cycle for 4 cycles -> grants alternate r0, r1, r0, r1; rd_id follows the same sequence one cycle later.
- Write addr 10 while r1 reads addr 10 in the same cycle -> r1_gnt = 0, wean = 0; next cycle r1_gnt = 1 and rd_data = the new value.
- 912 sequential writes -> wr_cnt reaches 911 and then wraps to 0; frame_done pulses exactly once.
- Write addr 912 and read addr 1000 -> both consumed, no SRAM enables, no rd_valid, err_oor = 1 until clear.
- Assert rst_n low one cycle after a grant -> rd_valid stays 0 and all outputs hold their reset values.
